alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Execute-stage wrapper that sits directly upstream of the `alu` combinational datapath and downstream of the microcode sequencer. It accepts one ALU request per handshake, registers the operands and `alu_operation_e` op, and presents them to `alu`. It captures the result and flags, then models the multi-cycle cost of shift/rotate counts and, optionally, multiplies. It signals completion with a one-cycle `done` pulse and holds the committed result and flags until the next completion.

## Interface
- `STALL_MAX`, 31: saturation limit for the stall counter. Caps `alu_cycles` plus the multiply penalty. Range 0..63.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request valid. Accepted only when `ready`=1.
- `ready` out 1: stage can accept a request this cycle.
- `op_in` in `alu_operation_e`: operation.
- `ta_in`, `tb_in` in 16: operands.
- `wide_in` in 1: 1 = word, 0 = byte.
- `flags_in` in `flags_t`: architectural flags, sampled at accept.
- `abort` in 1: cancel the in-flight request.
- `alu_op` out `alu_operation_e`: registered operation to `alu`.
- `alu_ta`, `alu_tb` out 16: registered operands to `alu`.
- `alu_wide` out 1: registered width to `alu`.
- `alu_flags` out `flags_t`: registered flags to `alu`.
- `alu_result` in 32, `alu_cycles` in 6, `alu_flags_res` in `flags_t`: outputs returned from `alu`.
- `busy` out 1: request in flight (EXEC or WAIT).
- `done` out 1: one-cycle completion pulse.
- `result_out` out 32: committed result.
- `flags_out` out `flags_t`: committed flags.

## Operation
- States: IDLE, EXEC, WAIT, DONE.
- **IDLE**
  - `ready`=1.
  - On `start`: latch op/ta/tb/wide/flags into the `alu_*` registers; go to EXEC.
- **EXEC** (`alu` evaluates the latched operands combinationally)
  - Capture `alu_result` and `alu_flags_res` into a pending register.
  - Compute stall = `alu_cycles` + multiply penalty (see Configuration), saturated at `STALL_MAX`.
  - Stall = 0: go to DONE.
  - Otherwise load the 6-bit counter with stall; go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reads 1, go to DONE.
- **DONE**
  - `done`=1; `result_out` and `flags_out` take the pending values.
  - `ready`=1. `start` in this cycle is accepted and goes to EXEC (back-to-back); otherwise go to IDLE.
- **Result holding:** `result_out` and `flags_out` change only in DONE and hold otherwise.
- **Byte ops:** `result_out[31:8]` is whatever `alu` returns. The stage does no masking.
- **`start` while `busy`:** ignored, no queuing.
- **`abort` in EXEC or WAIT:** go to IDLE on the next edge. No `done`; `result_out` and `flags_out` are unchanged.
- **`abort` in IDLE or DONE:** no effect. In DONE, `done` still fires.
- **`abort` and `start` in the same DONE cycle:** the new request is accepted.

## Timing
- Reset values:
  - State IDLE; `ready`=1.
  - `busy`=0, `done`=0.
  - `result_out`=0, `flags_out`=0.
  - All `alu_*` registers 0; `alu_op`=`ALU_OP_ADD`.
  - Counter 0.
- Latency from the `start` accept edge to the `done` cycle is 2 + stall cycles:
  - stall 0: `done` in cycle N+2;
  - ROL wide with `tb`=5: `done` in cycle N+7.
- Back-to-back single-cycle ops complete every 2 cycles.
- Reset asserted mid-operation forces IDLE immediately (asynchronous). No `done` follows deassertion.

## Configuration
- `ALU_MUL_STALL_EN`, defined:
  - `ALU_OP_MUL`/`ALU_OP_MULU` add a fixed penalty: 3 cycles byte, 11 cycles word.
  - The penalty adds to `alu_cycles` before saturation.
- Not defined: multiplies add 0 cycles and complete like ADD.

## Test plan
- ADD word, `ta`=0x7FFF, `tb`=0x0001, flags 0, accepted cycle 0 -> `done` at cycle 2; `result_out`=0x00008000; `flags_out` V=1, S=1, Z=0, CY=0.
- ROL word, `ta`=0x8001, `tb`=5 -> `done` at cycle 7; `result_out[15:0]`=0x0030; `busy`=1 cycles 1-6.
- RORC word, `tb`=20, `abort` at cycle 4 -> state IDLE at cycle 5; no `done`; `result_out` keeps its prior value.
- Two ADDs, second `start` in the first's DONE cycle -> `done` pulses at cycles 2 and 4; each `result_out` is correct.
- MUL word 0x0100×0x0100 -> with `ALU_MUL_STALL_EN`: `done` at cycle 13, result 0x00010000, CY=V=1; without the macro: `done` at cycle 2.
- `reset_n` low during WAIT -> `ready`=1, `busy`=0, `result_out`=0 immediately; no `done` after release.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage wrapper between the microcode sequencer and
// the combinational alu. Accepts one request per start/ready handshake,
// registers the operands for the alu, captures its result/flags, stalls for
// the alu-reported cycle count (plus an optional multiply penalty), then
// commits the result with a one-cycle done pulse.
//
// Optional feature macro: ALU_MUL_STALL_EN (adds 3/11 stall cycles to
// byte/word ALU_OP_MUL and ALU_OP_MULU).
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   start/ready                   request handshake
//   op_in, ta_in, tb_in, wide_in,
//   flags_in                      request payload, sampled at accept
//   abort                         cancel in-flight request (EXEC/WAIT)
//   alu_op, alu_ta, alu_tb,
//   alu_wide, alu_flags           registered operands to alu
//   alu_result, alu_cycles,
//   alu_flags_res                 alu outputs
//   busy, done                    in-flight status, completion pulse
//   result_out, flags_out         committed result and flags

package alu_exec_pkg;

  typedef enum logic [4:0] {
    ALU_OP_ADD  = 5'd0,
    ALU_OP_ADC  = 5'd1,
    ALU_OP_SUB  = 5'd2,
    ALU_OP_SBB  = 5'd3,
    ALU_OP_AND  = 5'd4,
    ALU_OP_OR   = 5'd5,
    ALU_OP_XOR  = 5'd6,
    ALU_OP_CMP  = 5'd7,
    ALU_OP_SHL  = 5'd8,
    ALU_OP_SHR  = 5'd9,
    ALU_OP_SAR  = 5'd10,
    ALU_OP_ROL  = 5'd11,
    ALU_OP_ROR  = 5'd12,
    ALU_OP_ROLC = 5'd13,
    ALU_OP_RORC = 5'd14,
    ALU_OP_MUL  = 5'd15,
    ALU_OP_MULU = 5'd16
  } alu_operation_e;

  typedef struct packed {
    logic v;
    logic s;
    logic z;
    logic cy;
  } flags_t;

endpackage

module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int unsigned STALL_MAX = 31
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  output logic           ready,
  input  alu_operation_e op_in,
  input  logic [15:0]    ta_in,
  input  logic [15:0]    tb_in,
  input  logic           wide_in,
  input  flags_t         flags_in,
  input  logic           abort,
  output alu_operation_e alu_op,
  output logic [15:0]    alu_ta,
  output logic [15:0]    alu_tb,
  output logic           alu_wide,
  output flags_t         alu_flags,
  input  logic [31:0]    alu_result,
  input  logic [5:0]     alu_cycles,
  input  flags_t         alu_flags_res,
  output logic           busy,
  output logic           done,
  output logic [31:0]    result_out,
  output flags_t         flags_out
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] STALL_CAP = CNT_W'(STALL_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept;
  logic [31:0]      pend_result;
  flags_t           pend_flags;
  logic [31:0]      commit_result;
  flags_t           commit_flags;
  logic [SUM_W-1:0] mul_pen;
  logic [SUM_W-1:0] stall_sum;
  logic [CNT_W-1:0] stall;

  // Multiply penalty (zero unless the feature is built in)
`ifdef ALU_MUL_STALL_EN
  always_comb begin
    mul_pen = '0;
    if (alu_op == ALU_OP_MUL || alu_op == ALU_OP_MULU)
      mul_pen = alu_wide ? SUM_W'(11) : SUM_W'(3);
  end
`else
  always_comb begin
    mul_pen = '0;
  end
`endif

  // Total stall, saturated at STALL_MAX
  always_comb begin
    stall_sum = SUM_W'(alu_cycles) + mul_pen;
    stall     = (stall_sum > SUM_W'(STALL_CAP)) ? STALL_CAP : stall_sum[CNT_W-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state, counter and commit selection
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    accept        = 1'b0;
    // Zero-stall ops commit straight from the alu; the pending copy is not
    // loaded until the same edge.
    commit_result = (state == S_EXEC) ? alu_result    : pend_result;
    commit_flags  = (state == S_EXEC) ? alu_flags_res : pend_flags;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (stall == '0) begin
          state_next = S_DONE;
        end else begin
          cnt_next   = stall;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_EXEC;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      alu_op      <= ALU_OP_ADD;
      alu_ta      <= '0;
      alu_tb      <= '0;
      alu_wide    <= 1'b0;
      alu_flags   <= '0;
      pend_result <= '0;
      pend_flags  <= '0;
      result_out  <= '0;
      flags_out   <= '0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (accept) begin
        alu_op    <= op_in;
        alu_ta    <= ta_in;
        alu_tb    <= tb_in;
        alu_wide  <= wide_in;
        alu_flags <= flags_in;
      end
      if (state == S_EXEC) begin
        pend_result <= alu_result;
        pend_flags  <= alu_flags_res;
      end
      if (state_next == S_DONE) begin
        result_out <= commit_result;
        flags_out  <= commit_flags;
      end
      ready <= (state_next == S_IDLE) || (state_next == S_DONE);
      busy  <= (state_next == S_EXEC) || (state_next == S_WAIT);
      done  <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage with a small behavioural
// alu model supplying result, flags and cycle counts.
module tb_alu_exec_stage;
  import alu_exec_pkg::*;

`ifdef ALU_MUL_STALL_EN
  localparam int MUL_W_LAT = 13;
  localparam int MUL_B_LAT = 5;
`else
  localparam int MUL_W_LAT = 2;
  localparam int MUL_B_LAT = 2;
`endif

  logic           clk;
  logic           reset_n;
  logic           start;
  logic           ready;
  alu_operation_e op_in;
  logic [15:0]    ta_in, tb_in;
  logic           wide_in;
  flags_t         flags_in;
  logic           abort;
  alu_operation_e alu_op;
  logic [15:0]    alu_ta, alu_tb;
  logic           alu_wide;
  flags_t         alu_flags;
  logic [31:0]    alu_result;
  logic [5:0]     alu_cycles;
  flags_t         alu_flags_res;
  logic           busy, done;
  logic [31:0]    result_out;
  flags_t         flags_out;

  int passed = 0;
  int total  = 0;

  alu_exec_stage #(.STALL_MAX(31)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready),
    .op_in(op_in), .ta_in(ta_in), .tb_in(tb_in), .wide_in(wide_in),
    .flags_in(flags_in), .abort(abort),
    .alu_op(alu_op), .alu_ta(alu_ta), .alu_tb(alu_tb), .alu_wide(alu_wide),
    .alu_flags(alu_flags), .alu_result(alu_result), .alu_cycles(alu_cycles),
    .alu_flags_res(alu_flags_res), .busy(busy), .done(done),
    .result_out(result_out), .flags_out(flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu: ADD, ROL, RORC, MUL/MULU
  logic [16:0] sum17;
  logic [8:0]  sum9;
  logic [31:0] rot, prod;
  always_comb begin
    alu_result    = '0;
    alu_cycles    = '0;
    alu_flags_res = '0;
    sum17 = '0;
    sum9  = '0;
    rot   = '0;
    prod  = '0;
    case (alu_op)
      ALU_OP_ADD: begin
        alu_result = 32'(alu_ta) + 32'(alu_tb);
        if (alu_wide) begin
          sum17 = {1'b0, alu_ta} + {1'b0, alu_tb};
          alu_flags_res.cy = sum17[16];
          alu_flags_res.z  = (sum17[15:0] == 16'h0);
          alu_flags_res.s  = sum17[15];
          alu_flags_res.v  = (alu_ta[15] == alu_tb[15]) && (sum17[15] != alu_ta[15]);
        end else begin
          sum9 = {1'b0, alu_ta[7:0]} + {1'b0, alu_tb[7:0]};
          alu_flags_res.cy = sum9[8];
          alu_flags_res.z  = (sum9[7:0] == 8'h0);
          alu_flags_res.s  = sum9[7];
          alu_flags_res.v  = (alu_ta[7] == alu_tb[7]) && (sum9[7] != alu_ta[7]);
        end
      end
      ALU_OP_ROL: begin
        rot = {alu_ta, alu_ta} << alu_tb[3:0];
        alu_result       = {16'h0, rot[31:16]};
        alu_flags_res.cy = rot[16];
        alu_cycles       = alu_tb[5:0];
      end
      ALU_OP_RORC: begin
        alu_result = 32'(alu_ta);
        alu_cycles = alu_tb[5:0];
      end
      ALU_OP_MUL, ALU_OP_MULU: begin
        if (alu_wide) begin
          prod = 32'(alu_ta) * 32'(alu_tb);
          alu_flags_res.cy = |prod[31:16];
        end else begin
          prod = 32'(alu_ta[7:0]) * 32'(alu_tb[7:0]);
          alu_flags_res.cy = |prod[15:8];
        end
        alu_flags_res.v = alu_flags_res.cy;
        alu_result      = prod;
      end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Issue a request from IDLE or DONE and run until done (bounded).
  // poke_at: cycle at which a stray start is driven (0 = none).
  task automatic run_op(input alu_operation_e op, input logic [15:0] a, input logic [15:0] b,
                        input logic w, input logic ab0, input int poke_at,
                        output int lat, output int busy_cyc);
    op_in = op; ta_in = a; tb_in = b; wide_in = w; flags_in = '0;
    abort = ab0; start = 1'b1;
    lat = 0; busy_cyc = 0;
    do begin
      step();
      lat++;
      start = 1'b0;
      abort = 1'b0;
      if (lat == poke_at) begin
        op_in = ALU_OP_ADD; ta_in = 16'h1111; start = 1'b1;
      end
      if (busy) busy_cyc++;
    end while (!done && lat < 100);
  endtask

  int lat, bcyc, ndone;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    op_in = ALU_OP_ADD; ta_in = '0; tb_in = '0; wide_in = 1'b0; flags_in = '0;
    repeat (3) step();

    // Reset state
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result_out, 32'h0);
    chk("rst_flags", 32'(flags_out), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
    chk("rst_alu_ta", 32'(alu_ta), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    step();

    // ADD word overflow
    run_op(ALU_OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 0, lat, bcyc);
    chk("add_lat", 32'(lat), 32'd2);
    chk("add_result", result_out, 32'h0000_8000);
    chk("add_flags", 32'(flags_out), 32'b1100);
    step();
    chk("add_done_pulse", 32'(done), 32'd0);
    chk("add_hold", result_out, 32'h0000_8000);

    // ROL word by 5 with stray start while busy
    run_op(ALU_OP_ROL, 16'h8001, 16'd5, 1'b1, 1'b0, 3, lat, bcyc);
    chk("rol_lat", 32'(lat), 32'd7);
    chk("rol_busy_cycles", 32'(bcyc), 32'd6);
    chk("rol_result", result_out, 32'h0000_0030);
    chk("rol_ignored_start", 32'(alu_ta), 32'h8001);
    chk("rol_busy_at_done", 32'(busy), 32'd0);
    step();

    // Byte ADD: upper bits pass through unmasked
    run_op(ALU_OP_ADD, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, lat, bcyc);
    chk("addb_lat", 32'(lat), 32'd2);
    chk("addb_result", result_out, 32'h0000_0100);
    chk("addb_flags", 32'(flags_out), 32'b0011);

    // Back-to-back ADDs (second start in first DONE cycle)
    step();
    run_op(ALU_OP_ADD, 16'h0001, 16'h0002, 1'b1, 1'b0, 0, lat, bcyc);
    chk("b2b1_lat", 32'(lat), 32'd2);
    chk("b2b1_result", result_out, 32'h3);
    chk("b2b1_ready", 32'(ready), 32'd1);
    run_op(ALU_OP_ADD, 16'h0010, 16'h0020, 1'b1, 1'b0, 0, lat, bcyc);
    chk("b2b2_lat", 32'(lat), 32'd2);
    chk("b2b2_result", result_out, 32'h30);

    // abort + start together in DONE: new request accepted
    run_op(ALU_OP_ADD, 16'h0003, 16'h0004, 1'b1, 1'b1, 0, lat, bcyc);
    chk("abdone_lat", 32'(lat), 32'd2);
    chk("abdone_result", result_out, 32'h7);
    step();

    // abort in IDLE: no effect
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abidle_ready", 32'(ready), 32'd1);
    chk("abidle_busy", 32'(busy), 32'd0);

    // RORC by 20, abort in cycle 4
    op_in = ALU_OP_RORC; ta_in = 16'hABCD; tb_in = 16'd20; wide_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      step();
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_result_kept", result_out, 32'h7);

    // Stall saturation: ROL count 40 caps at 31
    run_op(ALU_OP_ROL, 16'h1234, 16'd40, 1'b1, 1'b0, 0, lat, bcyc);
    chk("sat_lat", 32'(lat), 32'd33);
    chk("sat_result", result_out, 32'h0000_3412);
    step();

    // MUL word and byte
    run_op(ALU_OP_MUL, 16'h0100, 16'h0100, 1'b1, 1'b0, 0, lat, bcyc);
    chk("mulw_lat", 32'(lat), 32'(MUL_W_LAT));
    chk("mulw_result", result_out, 32'h0001_0000);
    chk("mulw_flags", 32'(flags_out), 32'b1001);
    step();
    run_op(ALU_OP_MULU, 16'h0010, 16'h0010, 1'b0, 1'b0, 0, lat, bcyc);
    chk("mulb_lat", 32'(lat), 32'(MUL_B_LAT));
    chk("mulb_result", result_out, 32'h0000_0100);
    step();

    // Async reset during WAIT
    op_in = ALU_OP_ROL; ta_in = 16'h0F0F; tb_in = 16'd10; wide_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("rstw_busy_before", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_ready", 32'(ready), 32'd1);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_result", result_out, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) ndone++;
    end
    chk("rstw_no_done", 32'(ndone), 32'd0);
    chk("rstw_ready_after", 32'(ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
